// File: rtl/sys_defs.sv
// Shared Dmem bus definitions: command encoding, tag type, load-slot record and
// default memory geometry.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef logic [3:0] MEM_TAG;

  localparam int unsigned MEM_LATENCY_IN_CYCLES = 4;
  localparam int unsigned MEM_64BIT_LINES       = 8192;
  localparam int unsigned MEM_CNT_W             = $clog2(MEM_LATENCY_IN_CYCLES + 1);

  typedef struct packed {
    logic                 valid;
    logic [MEM_CNT_W-1:0] count;
    logic [63:0]          data;
  } MEM_LOAD_SLOT;

endpackage

// File: rtl/mem_tag_alloc.sv
// Lowest-free-tag priority encoder over the load-slot busy vector.
// Slot i carries tag i+1; tag 0 is reserved for "no tag".
module mem_tag_alloc
  import sys_defs::*;
#(
  parameter int unsigned NUM_TAGS = 15
) (
  input  logic [NUM_TAGS-1:0] i_busy,
  output logic [3:0]          o_tag,
  output logic                o_none_free
);

  MEM_TAG w_tag;

  // Scan from the top down so the lowest free slot wins.
  always_comb begin
    w_tag       = '0;
    o_none_free = 1'b1;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!i_busy[i]) begin
        w_tag       = MEM_TAG'(i + 1);
        o_none_free = 1'b0;
      end
    end
  end

  assign o_tag = w_tag;

endmodule

// File: rtl/mem_tag_responder.sv
// Memory-side end of the tagged Dmem bus: grants tags, writes stores immediately and
// returns snapshotted load data MEM_LATENCY cycles after acceptance.
module mem_tag_responder
  import sys_defs::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_IN_CYCLES,
  parameter int unsigned NUM_TAGS    = 15,
  parameter int unsigned MEM_LINES   = MEM_64BIT_LINES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam int unsigned IdxW = $clog2(MEM_LINES);

  if (NUM_TAGS < 1 || NUM_TAGS > 15) begin : g_bad_num_tags
    $error("mem_tag_responder: NUM_TAGS must be within 1..15");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_tag_responder: MEM_LATENCY must be at least 1");
  end

  logic [NUM_TAGS-1:0] r_valid;
  logic [CntW-1:0]     r_count [NUM_TAGS];
  logic [63:0]         r_sdata [NUM_TAGS];
  MEM_TAG              r_tag;
  logic [63:0]         r_out_data;
  logic [63:0]         r_mem   [MEM_LINES];

  MEM_TAG      w_alloc_tag;
  logic        w_none_free;
  logic [28:0] w_line;
  logic        w_in_range;
  logic [IdxW-1:0] w_mem_idx;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_load_acc;
  logic        w_store_acc;
  logic [63:0] w_rd_data;
  logic        w_fire;
  MEM_TAG      w_fire_tag;
  logic [63:0] w_fire_data;
  logic        w_unused;

  mem_tag_alloc #(
    .NUM_TAGS(NUM_TAGS)
  ) u_alloc (
    .i_busy     (r_valid),
    .o_tag      (w_alloc_tag),
    .o_none_free(w_none_free)
  );

  assign w_line      = proc2mem_addr[31:3];
  assign w_in_range  = (32'(w_line) < MEM_LINES);
  assign w_mem_idx   = proc2mem_addr[IdxW+2:3];
  assign w_is_load   = (proc2mem_command == BUS_LOAD);
  assign w_is_store  = (proc2mem_command == BUS_STORE);
  assign w_load_acc  = reset && w_is_load && w_in_range && !w_none_free;
  assign w_store_acc = reset && w_is_store && w_in_range;
  assign w_rd_data   = r_mem[w_mem_idx];
  assign w_unused    = ^proc2mem_addr[2:0];

  always_comb begin
    mem2proc_response = '0;
    if (w_load_acc) begin
      mem2proc_response = w_alloc_tag;
    end else if (w_store_acc) begin
      mem2proc_response = 4'd1;
    end
  end

  // A slot at zero that is not already on the output is due next edge. The slot stays
  // busy while its completion is presented, so it cannot be reallocated that cycle.
  always_comb begin
    w_fire      = 1'b0;
    w_fire_tag  = '0;
    w_fire_data = '0;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      if (r_valid[i] && (r_count[i] == '0) && (r_tag != MEM_TAG'(i + 1))) begin
        w_fire      = 1'b1;
        w_fire_tag  = MEM_TAG'(i + 1);
        w_fire_data = r_sdata[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_tag      <= '0;
      r_out_data <= '0;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        r_count[i] <= '0;
        r_sdata[i] <= '0;
      end
    end else begin
      r_tag      <= w_fire ? w_fire_tag : '0;
      r_out_data <= w_fire ? w_fire_data : '0;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        if (r_valid[i] && (r_count[i] != '0)) begin
          r_count[i] <= r_count[i] - 1'b1;
        end
        if (r_valid[i] && (r_tag == MEM_TAG'(i + 1))) begin
          r_valid[i] <= 1'b0;
        end
        if (w_load_acc && (w_alloc_tag == MEM_TAG'(i + 1))) begin
          r_valid[i] <= 1'b1;
          r_count[i] <= CntW'(MEM_LATENCY - 1);
          r_sdata[i] <= w_rd_data;
        end
      end
    end
  end

  // Backing store survives reset.
  always_ff @(posedge clock) begin
    if (w_store_acc) begin
      r_mem[w_mem_idx] <= proc2mem_data;
    end
  end

  assign mem2proc_tag  = r_tag;
  assign mem2proc_data = r_out_data;

endmodule

// File: tb/tb_mem_tag_responder.sv
// Directed plus randomized checks of mem_tag_responder against a tag/due-cycle reference
// model of the Dmem bus.
module tb_mem_tag_responder;
  import sys_defs::*;

  localparam int LAT   = 20;
  localparam int NT    = 15;
  localparam int LINES = 8192;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd   = 2'd0;
  logic [31:0] addr  = '0;
  logic [63:0] wdata = '0;
  logic [3:0]  resp;
  logic [63:0] rdata;
  logic [3:0]  tag;

  always #5 clock = ~clock;

  mem_tag_responder #(
    .MEM_LATENCY(LAT),
    .NUM_TAGS   (NT),
    .MEM_LINES  (LINES)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2mem_command (cmd),
    .proc2mem_addr    (addr),
    .proc2mem_data    (wdata),
    .mem2proc_response(resp),
    .mem2proc_data    (rdata),
    .mem2proc_tag     (tag)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a tag is busy from its acceptance edge until one edge after its due cycle.
  bit          busy_m [1:NT];
  int          due_m  [1:NT];
  logic [63:0] dat_m  [1:NT];
  logic [63:0] mem_m  [int];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_resp(input logic [1:0] c, input logic [31:0] a);
    if (reset !== 1'b1) return 4'd0;
    if (32'(a[31:3]) >= 32'(LINES)) return 4'd0;
    if (c == 2'd2) return 4'd1;
    if (c == 2'd1) begin
      for (int t = 1; t <= NT; t++) if (!busy_m[t]) return 4'(t);
    end
    return 4'd0;
  endfunction

  task automatic model_edge(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                            input logic [3:0] r);
    int line;
    line = int'(a[31:3]);
    cyc++;
    for (int t = 1; t <= NT; t++) if (busy_m[t] && due_m[t] + 1 == cyc) busy_m[t] = 1'b0;
    if (r != 4'd0 && c == 2'd1) begin
      busy_m[r] = 1'b1;
      due_m[r]  = cyc + LAT;
      dat_m[r]  = mem_m.exists(line) ? mem_m[line] : 64'd0;
    end else if (r != 4'd0 && c == 2'd2) begin
      mem_m[line] = d;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_tag;
    exp_tag = 4'd0;
    for (int t = 1; t <= NT; t++) if (busy_m[t] && due_m[t] == cyc) exp_tag = 4'(t);
    check("completion tag", 64'(tag), 64'(exp_tag));
    if (exp_tag != 4'd0) check("completion data", rdata, dat_m[exp_tag]);
  endtask

  // One bus cycle; want >= 0 additionally pins the response to a directed constant.
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                      input int want);
    logic [3:0] er;
    cmd = c; addr = a; wdata = d;
    #1;
    er = model_resp(c, a);
    check("response", 64'(resp), 64'(er));
    if (want >= 0) check("directed response", 64'(resp), 64'(want));
    @(posedge clock);
    model_edge(c, a, d, er);
    #1;
    check_outputs();
    cmd = 2'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'd0, 32'd0, 64'd0, -1);
  endtask

  task automatic do_reset(input int n);
    cmd = 2'd1; addr = 32'd16;
    reset = 1'b0;
    for (int t = 1; t <= NT; t++) busy_m[t] = 1'b0;
    #1;
    check("reset response", 64'(resp), 64'd0);
    check("reset tag", 64'(tag), 64'd0);
    check("reset data", rdata, 64'd0);
    repeat (n) begin
      @(posedge clock);
      cyc++;
      #1;
      check("reset response", 64'(resp), 64'd0);
      check("reset tag", 64'(tag), 64'd0);
    end
    cmd = 2'd0;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] d;
    int          r;
    #1;
    // 1. reset, then an idle bus
    do_reset(2);
    idle(3);

    // Known contents for every line the bench will read.
    for (int l = 0; l < 32; l++) begin
      d = {32'hA5A5_0000 | 32'(l), $urandom};
      step(2'd2, 32'(l * 8), d, 1);
    end
    step(2'd2, 32'd2832, 64'd0, 1);

    // 2. store then load of the same line
    step(2'd2, 32'd16, 64'd107, 1);
    step(2'd1, 32'd16, 64'd0, 1);
    idle(LAT + 2);

    // 3. fill all tags, overflow load, store while full, in-order drain
    for (int i = 0; i < NT; i++) step(2'd1, 32'(i * 8), 64'd0, i + 1);
    step(2'd1, 32'd120, 64'd0, 0);
    step(2'd2, 32'd120, 64'h0123_4567_89AB_CDEF, 1);
    idle(LAT + NT + 2);

    // 4. load snapshot is unaffected by a later store
    step(2'd1, 32'd2832, 64'd0, 1);
    step(2'd2, 32'd2832, 64'd1122, 1);
    idle(LAT + 2);
    step(2'd1, 32'd2832, 64'd0, 1);
    idle(LAT + 2);

    // 5. reset mid-latency drops the load; memory survives
    step(2'd1, 32'd24, 64'd0, 1);
    idle(3);
    do_reset(2);
    idle(LAT + 3);
    step(2'd1, 32'd16, 64'd0, 1);
    idle(LAT + 2);

    // 6. out-of-range and command 3 are ignored
    step(2'd1, 32'(LINES * 8), 64'd0, 0);
    step(2'd2, 32'((LINES + 2) * 8), 64'hDEAD, 0);
    step(2'd3, 32'd16, 64'hBEEF, 0);
    idle(LAT + 2);
    step(2'd1, 32'd16, 64'd0, 1);
    step(2'd1, 32'd2832, 64'd0, 2);
    idle(LAT + 3);

    // Randomized traffic over the known lines.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      d = {$urandom, $urandom};
      if (r <= 3)      step(2'd1, $urandom_range(0, 255), d, -1);
      else if (r <= 5) step(2'd2, $urandom_range(0, 255), d, -1);
      else if (r == 6) step(2'd0, $urandom, d, -1);
      else if (r == 7) step(2'd3, $urandom_range(0, 255), d, -1);
      else             step(2'($urandom_range(1, 2)),
                            32'(LINES * 8) + $urandom_range(0, 4000), d, -1);
    end
    idle(LAT + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
